dmem_byte_arbiter: RTL

//  Shares the byte-wide data memory between two word requesters: the processor load/store path (cpu_*) and a host loader/debug port (host_*).

---
 rtl/dmem_byte_arbiter_if.sv | 50 +++++
 rtl/dmem_byte_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dmem_byte_arbiter_if.sv
// Word-request / byte-memory bundle shared by the data-memory arbiter and its
// neighbours (CPU load/store path, host loader, byte-wide memory array).
interface dmem_byte_arbiter_if #(
   parameter int ADDR_W = 5
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic              cpu_ack;
   logic [31:0]       cpu_rdata;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [31:0]       host_wdata;
   logic              host_ack;
   logic [31:0]       host_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   logic              busy;
   logic              grant_host;

   // Arbiter side.
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata,
      input  host_req, host_we, host_addr, host_wdata,
      output host_ack, host_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy, grant_host
   );

   // Requesters plus the byte memory.
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata,
      output host_req, host_we, host_addr, host_wdata,
      input  host_ack, host_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy, grant_host
   );
endinterface

// File: rtl/dmem_byte_arbiter.sv
// Round-robin arbiter giving the CPU and host word ports access to a byte-wide
// data memory; each word becomes four big-endian byte cycles (MSB at lowest address).
module dmem_byte_arbiter #(
   parameter int ADDR_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   dmem_byte_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_reg;
   logic [1:0]        byte_cnt_reg;
   logic              we_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       wdata_reg;
   logic [31:0]       shadow_reg;
   logic              last_host_reg;
   logic              grant_host_reg;
   logic              busy_reg;
   logic              cpu_ack_reg;
   logic              host_ack_reg;
   logic [31:0]       cpu_rdata_reg;
   logic [31:0]       host_rdata_reg;
   logic              mem_en_reg;
   logic              mem_we_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [7:0]        mem_wdata_reg;

   logic              grant_any;
   logic              pick_host;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic [1:0]        byte_cnt_inc;
   logic [7:0]        wr_lane [4];
   logic [31:0]       cap_word;

   // On a tie the requester that did not own the previous transaction wins.
   assign grant_any    = bus.cpu_req | bus.host_req;
   assign pick_host    = bus.host_req & (~bus.cpu_req | ~last_host_reg);
   assign sel_we       = pick_host ? bus.host_we    : bus.cpu_we;
   assign sel_addr     = pick_host ? bus.host_addr  : bus.cpu_addr;
   assign sel_wdata    = pick_host ? bus.host_wdata : bus.cpu_wdata;
   assign byte_cnt_inc = byte_cnt_reg + 2'd1;

   // Lane gi is the byte at word offset gi, i.e. bits [31-8*gi -: 8].
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign wr_lane[gi] = wdata_reg[31-8*gi -: 8];
         assign cap_word[31-8*gi -: 8] = (byte_cnt_reg == 2'(gi)) ? bus.mem_rdata
                                                                  : shadow_reg[31-8*gi -: 8];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         byte_cnt_reg   <= 2'd0;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= 32'd0;
         shadow_reg     <= 32'd0;
         last_host_reg  <= 1'b1;
         grant_host_reg <= 1'b0;
         busy_reg       <= 1'b0;
         cpu_ack_reg    <= 1'b0;
         host_ack_reg   <= 1'b0;
         cpu_rdata_reg  <= 32'd0;
         host_rdata_reg <= 32'd0;
         mem_en_reg     <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= 8'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_any) begin
                  state_reg      <= XFER;
                  byte_cnt_reg   <= 2'd0;
                  we_reg         <= sel_we;
                  addr_reg       <= sel_addr;
                  wdata_reg      <= sel_wdata;
                  grant_host_reg <= pick_host;
                  busy_reg       <= 1'b1;
                  mem_en_reg     <= 1'b1;
                  mem_we_reg     <= sel_we;
                  mem_addr_reg   <= sel_addr;
                  mem_wdata_reg  <= sel_wdata[31:24];
               end
            end
            XFER: begin
               if (!we_reg) begin
                  shadow_reg <= cap_word;
               end
               if (byte_cnt_reg == 2'd3) begin
                  state_reg  <= DONE;
                  mem_en_reg <= 1'b0;
                  mem_we_reg <= 1'b0;
                  // Read data goes out together with the ack, straight from the capture path.
                  if (grant_host_reg) begin
                     host_ack_reg <= 1'b1;
                     if (!we_reg) begin
                        host_rdata_reg <= cap_word;
                     end
                  end else begin
                     cpu_ack_reg <= 1'b1;
                     if (!we_reg) begin
                        cpu_rdata_reg <= cap_word;
                     end
                  end
               end else begin
                  byte_cnt_reg  <= byte_cnt_inc;
                  mem_addr_reg  <= addr_reg + ADDR_W'(byte_cnt_inc);
                  mem_wdata_reg <= wr_lane[byte_cnt_inc];
               end
            end
            DONE: begin
               cpu_ack_reg   <= 1'b0;
               host_ack_reg  <= 1'b0;
               last_host_reg <= grant_host_reg;
               busy_reg      <= 1'b0;
               state_reg     <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_ack    = cpu_ack_reg;
   assign bus.cpu_rdata  = cpu_rdata_reg;
   assign bus.host_ack   = host_ack_reg;
   assign bus.host_rdata = host_rdata_reg;
   assign bus.mem_en     = mem_en_reg;
   assign bus.mem_we     = mem_we_reg;
   assign bus.mem_addr   = mem_addr_reg;
   assign bus.mem_wdata  = mem_wdata_reg;
   assign bus.busy       = busy_reg;
   assign bus.grant_host = grant_host_reg;
endmodule
